// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer around the ID/EX register: load-use stalls with bubble
// injection, branch/jump flushes, and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int unsigned LU_STALL = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             jump_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01
    } state_t;

    localparam logic [3:0]       REM_INIT = 4'(LU_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       lu_haz;
    logic       stall_req;
    logic       stall_bubble;

    assign lu_haz = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) ||
                     (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    // In STALL the ID/EX stage already holds a bubble, so lu_haz is not re-evaluated.
    assign stall_req = (state_q == STALL) || ((state_q == RUN) && lu_haz);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_flush_o = 1'b0;
        stall_bubble  = 1'b0;
        state_d       = RUN;
        rem_d         = 4'd0;

        if (!rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (stall_req) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            stall_bubble  = 1'b1;
            if (state_q == STALL) begin
                if (rem_q > 4'd1) begin
                    state_d = STALL;
                    rem_d   = rem_q - 4'd1;
                end
            end else if (LU_STALL > 1) begin
                state_d = STALL;
                rem_d   = REM_INIT;
            end
        end else if (jump_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            rem_q       <= 4'd0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (stall_bubble && (stall_cnt_o != CNT_MAX))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (ifid_flush_o && (flush_cnt_o != CNT_MAX))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

    assign state_o = state_q;

endmodule
